// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs and the
// stall/flush/bubble controls returned to the pipeline.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_hilo;
  logic        ex_load;
  logic [4:0]  ex_rt;
  logic        ex_mult;
  logic        ex_redirect;
  logic        ex_syscall;
  logic        ex_eret;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        mult_busy;
  logic        exc_flushing;
  logic [31:0] stall_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_hilo,
    output ex_load, ex_rt, ex_mult, ex_redirect,
    output ex_syscall, ex_eret,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble,
    input  mult_busy, exc_flushing, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_hilo,
    input  ex_load, ex_rt, ex_mult, ex_redirect,
    input  ex_syscall, ex_eret,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble,
    output mult_busy, exc_flushing, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use and HI/LO interlocks,
// branch and exception-redirect flushes, stall cycle counter.
module hazard_ctrl #(
  parameter int MULT_LATENCY     = 4,
  parameter int EXC_FLUSH_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  localparam int MW = $clog2(MULT_LATENCY + 1);
  localparam int FW = $clog2(EXC_FLUSH_CYCLES + 1);

  typedef enum logic {RUN, EXC_FLUSH} state_e;

  state_e        state_q;
  logic [FW-1:0] fcnt_q;
  logic [MW-1:0] mcnt_q;
  logic [31:0]   stall_count_q;
  logic [31:0]   stall_count_d;

  logic exc, redir, load_hz, hilo_hz, mpend, flushing;

  assign flushing = (state_q == EXC_FLUSH);
  assign mpend    = (mcnt_q != '0);
  assign exc      = bus.ex_syscall | bus.ex_eret;
  assign redir    = (bus.ex_redirect | exc) & ~flushing;
  assign load_hz  = bus.ex_load & (|bus.ex_rt) &
                    ((bus.id_use_rs & (bus.id_rs == bus.ex_rt)) |
                     (bus.id_use_rt & (bus.id_rt == bus.ex_rt)));
  assign hilo_hz  = bus.id_hilo & (bus.ex_mult | mpend);

  always_comb begin
    bus.pc_stall    = 1'b0;
    bus.ifid_stall  = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    if (reset) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else begin
      priority case (1'b1)
        flushing, redir: begin
          bus.ifid_flush  = 1'b1;
          bus.idex_bubble = 1'b1;
        end
        load_hz, hilo_hz: begin
          bus.pc_stall    = 1'b1;
          bus.ifid_stall  = 1'b1;
          bus.idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (bus.pc_stall && stall_count_q != 32'hFFFF_FFFF)
      stall_count_d = stall_count_q + 32'd1;
  end

  assign bus.mult_busy    = ~reset & (bus.ex_mult | mpend);
  assign bus.exc_flushing = flushing;
  assign bus.stall_count  = stall_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      fcnt_q        <= '0;
      mcnt_q        <= '0;
      stall_count_q <= '0;
    end else begin
      // wrong-path exc/redirect seen while flushing is dropped
      unique case (state_q)
        RUN: begin
          if (exc) begin
            state_q <= EXC_FLUSH;
            fcnt_q  <= FW'(EXC_FLUSH_CYCLES - 1);
          end
        end
        EXC_FLUSH: begin
          if (fcnt_q == '0) state_q <= RUN;
          else              fcnt_q  <= fcnt_q - FW'(1);
        end
        default: state_q <= RUN;
      endcase
      if (bus.ex_mult)  mcnt_q <= MW'(MULT_LATENCY - 1);
      else if (mpend)   mcnt_q <= mcnt_q - MW'(1);
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: interlocks, flushes,
// async reset mid-flush and stall counter saturation.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  hazard_ctrl_if hif ();

  hazard_ctrl #(
    .MULT_LATENCY     (4),
    .EXC_FLUSH_CYCLES (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {pc_stall, ifid_stall, ifid_flush, idex_bubble}
  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, hif.pc_stall, hif.ifid_stall,
              hif.ifid_flush, hif.idex_bubble}, {28'd0, exp});
  endtask

  task automatic clr();
    hif.id_rs       = '0;
    hif.id_rt       = '0;
    hif.id_use_rs   = 1'b0;
    hif.id_use_rt   = 1'b0;
    hif.id_hilo     = 1'b0;
    hif.ex_load     = 1'b0;
    hif.ex_rt       = '0;
    hif.ex_mult     = 1'b0;
    hif.ex_redirect = 1'b0;
    hif.ex_syscall  = 1'b0;
    hif.ex_eret     = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    #2;
    chk_ctl("rst_ctl", 4'b0011);
    chk("rst_busy", {31'd0, hif.mult_busy}, 32'd0);
    chk("rst_excf", {31'd0, hif.exc_flushing}, 32'd0);
    chk("rst_cnt", hif.stall_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    next();

    // T1 load-use
    hif.ex_load = 1'b1; hif.ex_rt = 5'd8;
    hif.id_use_rs = 1'b1; hif.id_rs = 5'd8;
    @(negedge clk);
    chk_ctl("t1_hz", 4'b1101);
    next();
    hif.ex_rt = 5'd0; hif.id_rs = 5'd0;
    @(negedge clk);
    chk_ctl("t1_r0", 4'b0000);
    chk("t1_cnt", hif.stall_count, 32'd1);
    next();
    hif.ex_rt = 5'd5; hif.id_rt = 5'd5;
    hif.id_use_rs = 1'b0; hif.id_use_rt = 1'b0;
    @(negedge clk);
    chk_ctl("t1_nouse", 4'b0000);
    next();
    hif.id_use_rt = 1'b1;
    @(negedge clk);
    chk_ctl("t1_rt", 4'b1101);
    next();
    clr();

    // T2 mult: id_hilo held, stall 4 cycles (count 2 -> 6)
    hif.ex_mult = 1'b1; hif.id_hilo = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t2_stall%0d", i),
          {31'd0, hif.pc_stall}, {31'd0, i < 4});
      chk($sformatf("t2_busy%0d", i),
          {31'd0, hif.mult_busy}, {31'd0, i < 4});
      next();
      hif.ex_mult = 1'b0;
    end
    chk("t2_cnt", hif.stall_count, 32'd6);
    clr();

    // T3 branch beats load-use
    hif.ex_redirect = 1'b1;
    hif.ex_load = 1'b1; hif.ex_rt = 5'd3;
    hif.id_use_rs = 1'b1; hif.id_rs = 5'd3;
    @(negedge clk);
    chk_ctl("t3_ctl", 4'b0011);
    next();
    clr();
    @(negedge clk);
    chk("t3_run", {31'd0, hif.exc_flushing}, 32'd0);
    chk("t3_cnt", hif.stall_count, 32'd6);
    next();

    // T4 syscall, eret in flush window ignored
    hif.ex_syscall = 1'b1;
    @(negedge clk);
    chk_ctl("t4_c0", 4'b0011);
    chk("t4_x0", {31'd0, hif.exc_flushing}, 32'd0);
    next();
    hif.ex_syscall = 1'b0; hif.ex_eret = 1'b1;
    @(negedge clk);
    chk_ctl("t4_c1", 4'b0011);
    chk("t4_x1", {31'd0, hif.exc_flushing}, 32'd1);
    next();
    hif.ex_eret = 1'b0;
    @(negedge clk);
    chk_ctl("t4_c2", 4'b0000);
    chk("t4_x2", {31'd0, hif.exc_flushing}, 32'd0);
    next();

    // T5 async reset mid-flush with mcnt=2
    hif.ex_mult = 1'b1;
    next();
    hif.ex_mult = 1'b0; hif.ex_syscall = 1'b1;
    next();
    hif.ex_syscall = 1'b0; hif.id_hilo = 1'b1;
    @(negedge clk);
    chk("t5_pre_x", {31'd0, hif.exc_flushing}, 32'd1);
    chk("t5_pre_b", {31'd0, hif.mult_busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_x", {31'd0, hif.exc_flushing}, 32'd0);
    chk("t5_b", {31'd0, hif.mult_busy}, 32'd0);
    chk("t5_cnt", hif.stall_count, 32'd0);
    chk_ctl("t5_ctl", 4'b0011);
    @(negedge clk);
    chk_ctl("t5_hold", 4'b0011);
    reset = 1'b0;
    #1;
    chk_ctl("t5_post", 4'b0000);
    next();
    clr();

    // T6 saturation
    @(negedge clk);
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    next();
    hif.ex_load = 1'b1; hif.ex_rt = 5'd9;
    hif.id_use_rs = 1'b1; hif.id_rs = 5'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t6_st%0d", i), {31'd0, hif.pc_stall}, 32'd1);
      next();
      chk($sformatf("t6_cnt%0d", i), hif.stall_count, 32'hFFFF_FFFF);
    end
    clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
